// File: rtl/ca_pipe_pkg.sv
// Shared types for the gated pipeline register: flush FSM states and counter width.
package ca_pipe_pkg;

  typedef enum logic {
    GP_RUN   = 1'b0,
    GP_FLUSH = 1'b1
  } gp_state_e;

  localparam int BUBBLE_CNT_W = 16;

endpackage

// File: rtl/gated_pipe_ch.sv
// One registered data channel with zero > hold > load priority; an idle cycle loads zero.
module gated_pipe_ch
  import ca_pipe_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              hold,
  input  logic              zero,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = '0;
    if (zero) begin
      q_d = '0;
    end else if (hold) begin
      q_d = q_q;
    end else if (ld) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gated_pipe_reg.sv
// Registered multi-channel gate with stall hold, per-channel masking and a flush FSM.
// Optional bubble counter enabled by defining GATED_PIPE_BUBBLE_CNT_EN.
module gated_pipe_reg
  import ca_pipe_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     in_valid,
  input  logic                     gate_en,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     stall,
  input  logic                     flush,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic [BUBBLE_CNT_W-1:0]  bubble_cnt
);

  localparam int                FCNT_W       = $clog2(FLUSH_CYC + 1);
  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYC - 1);

  gp_state_e         state_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic              busy_q;
  logic              valid_q;
  logic              valid_d;
  logic              flush_all;
  logic              hold;
  logic              load;

  // A pending flush request or an active FLUSH state both override stall.
  assign flush_all = flush | (state_q == GP_FLUSH);
  assign hold      = stall & ~flush_all;
  assign load      = in_valid & gate_en;

  always_comb begin
    valid_d = 1'b0;
    if (flush_all) begin
      valid_d = 1'b0;
    end else if (hold) begin
      valid_d = valid_q;
    end else begin
      valid_d = load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GP_RUN;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (flush) begin
        if (FLUSH_CYC > 1) begin
          state_q <= GP_FLUSH;
          fcnt_q  <= FLUSH_RELOAD;
          busy_q  <= 1'b1;
        end
      end else if (state_q == GP_FLUSH) begin
        fcnt_q <= fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1)) begin
          state_q <= GP_RUN;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gated_pipe_ch #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .ld   (load & ch_en[i]),
      .hold (hold),
      .zero (flush_all),
      .d    (in_data[i*DATA_W +: DATA_W]),
      .q    (out_data[i*DATA_W +: DATA_W])
    );
  end

  assign out_valid = valid_q;
  assign busy      = busy_q;

`ifdef GATED_PIPE_BUBBLE_CNT_EN
  logic [BUBBLE_CNT_W-1:0] cnt_q;
  logic                    bubble_ev;

  // A bubble is any edge that writes valid to zero other than a stall hold.
  assign bubble_ev = ~hold & ~valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bubble_ev && (cnt_q != {BUBBLE_CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + BUBBLE_CNT_W'(1);
    end
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_gated_pipe_reg.sv
// Directed bench for gated_pipe_reg (DATA_W=16, NUM_CH=3, FLUSH_CYC=2).
module tb_gated_pipe_reg;

  localparam int DW = 16;
  localparam int NC = 3;
`ifdef GATED_PIPE_BUBBLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NC*DW-1:0] in_data;
  logic             in_valid;
  logic             gate_en;
  logic [NC-1:0]    ch_en;
  logic             stall;
  logic             flush;
  logic [NC*DW-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic [15:0]      bubble_cnt;

  int checks = 0;
  int passes = 0;

  gated_pipe_reg #(.DATA_W(DW), .NUM_CH(NC), .FLUSH_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .gate_en    (gate_en),
    .ch_en      (ch_en),
    .stall      (stall),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [NC*DW-1:0] d,
                           input logic v, input logic b);
    check({tag, "_data"}, 64'(out_data), 64'(d));
    check({tag, "_valid"}, 64'(out_valid), 64'(v));
    check({tag, "_busy"}, 64'(busy), 64'(b));
  endtask

  initial begin
    rst = 1'b1; in_data = '1; in_valid = 1'b1; gate_en = 1'b1;
    ch_en = 3'b111; stall = 1'b0; flush = 1'b0;
    #1;
    tick(); tick();
    check_out("reset", '0, 1'b0, 1'b0);
    check("reset_cnt", 64'(bubble_cnt), 64'd0);

    // channel masking
    rst = 1'b0; ch_en = 3'b101; in_data = {16'hC, 16'hB, 16'hA};
    tick();
    check_out("mask", {16'hC, 16'h0, 16'hA}, 1'b1, 1'b0);

    // stall hold
    ch_en = 3'b111; in_data = {3{16'h1234}};
    tick();
    check_out("load", {3{16'h1234}}, 1'b1, 1'b0);
    stall = 1'b1; in_data = {3{16'h5555}};
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", {3{16'h1234}}, 1'b1, 1'b0);
    end
    stall = 1'b0;

    // single flush pulse: two bubbles, busy for one
    in_data = {16'h3, 16'h2, 16'h1}; flush = 1'b1;
    tick();
    check_out("fl_b1", '0, 1'b0, 1'b1);
    flush = 1'b0;
    tick();
    check_out("fl_b2", '0, 1'b0, 1'b0);
    tick();
    check_out("fl_resume", {16'h3, 16'h2, 16'h1}, 1'b1, 1'b0);

    // re-pulse while in FLUSH restarts the sequence
    flush = 1'b1;
    tick();
    check_out("rp_b1", '0, 1'b0, 1'b1);
    tick();
    check_out("rp_b2", '0, 1'b0, 1'b1);
    flush = 1'b0;
    tick();
    check_out("rp_b3", '0, 1'b0, 1'b0);
    tick();
    check_out("rp_resume", {16'h3, 16'h2, 16'h1}, 1'b1, 1'b0);

    // flush beats stall; stall ignored inside FLUSH
    stall = 1'b1; flush = 1'b1;
    tick();
    check_out("sf_b1", '0, 1'b0, 1'b1);
    flush = 1'b0;
    tick();
    check_out("sf_b2", '0, 1'b0, 1'b0);
    stall = 1'b0;
    tick();
    check_out("sf_resume", {16'h3, 16'h2, 16'h1}, 1'b1, 1'b0);

    // gate off and all channels masked
    gate_en = 1'b0;
    tick();
    check_out("gate_off", '0, 1'b0, 1'b0);
    gate_en = 1'b1; ch_en = 3'b000;
    tick();
    check_out("all_masked", '0, 1'b1, 1'b0);
    ch_en = 3'b010; in_data = {16'hBEEF, 16'hCAFE, 16'hF00D};
    tick();
    check_out("mid_only", {16'h0, 16'hCAFE, 16'h0}, 1'b1, 1'b0);

    // reset mid-FLUSH
    flush = 1'b1;
    tick();
    flush = 1'b0; rst = 1'b1;
    tick();
    check_out("rst_mid_fl", '0, 1'b0, 1'b0);
    check("rst_mid_cnt", 64'(bubble_cnt), 64'd0);

    // bubble counter: 5 gated cycles + 2 flush bubbles, stalls excluded
    rst = 1'b0; gate_en = 1'b0; ch_en = 3'b111;
    for (int i = 0; i < 5; i++) tick();
    check("cnt_gate5", 64'(bubble_cnt), CNT_ON ? 64'd5 : 64'd0);
    gate_en = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b1;
    tick();
    check_out("cnt_fl_end", '0, 1'b0, 1'b0);
    tick(); tick();
    check("cnt_total", 64'(bubble_cnt), CNT_ON ? 64'd7 : 64'd0);
    check_out("cnt_stall_hold", '0, 1'b0, 1'b0);
    stall = 1'b0;
    tick();
    check_out("cnt_resume", {16'hBEEF, 16'hCAFE, 16'hF00D}, 1'b1, 1'b0);
    check("cnt_after", 64'(bubble_cnt), CNT_ON ? 64'd7 : 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
